// File: rtl/rob_isu_alloc.sv
// -----------------------------------------------------------------------------
// rob_isu_alloc
//
// Issue-side ROB allocator. It accepts in-order requests from upstream and tags
// each one with the next sequential ROB id. The tagged request goes downstream
// through a single pipeline register. A credit counter limits the number of
// requests in flight to the ROB depth. The ROB returns credits one per cycle.
//
// Parameters
//   ROB_SIZE   ROB depth and initial credit count (power of two, >= 2)
//   ROB_ID_W   ROB id width, $clog2(ROB_SIZE)
//   REQ_W      request payload width
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   u_req_*        upstream valid/ready/data handshake
//   d_req_*        downstream valid/ready, registered payload and ROB id
//   u_crdt_rtn     one credit returned this cycle (ROB credit-return strobe)
//   crdt_cnt       current free credits (0..ROB_SIZE)
//   crdt_err       sticky flag: a credit was returned while already full
// -----------------------------------------------------------------------------
module rob_isu_alloc #(
  parameter int ROB_SIZE = 8,
  parameter int ROB_ID_W = $clog2(ROB_SIZE),
  parameter int REQ_W    = 64
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                u_req_valid,
  output logic                u_req_ready,
  input  logic [REQ_W-1:0]    u_req_data,

  output logic                d_req_valid,
  input  logic                d_req_ready,
  output logic [REQ_W-1:0]    d_req_data,
  output logic [ROB_ID_W-1:0] d_req_rob_id,

  input  logic                u_crdt_rtn,
  output logic [ROB_ID_W:0]   crdt_cnt,
  output logic                crdt_err
);

  localparam logic [ROB_ID_W:0]   CRDT_FULL = (ROB_ID_W + 1)'(ROB_SIZE);
  localparam logic [ROB_ID_W:0]   CRDT_ONE  = (ROB_ID_W + 1)'(1);
  localparam logic [ROB_ID_W-1:0] PTR_ONE   = ROB_ID_W'(1);

  logic [ROB_ID_W:0]   crdt_cnt_q, crdt_cnt_d;
  logic [ROB_ID_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic                out_vld_q,  out_vld_d;
  logic [REQ_W-1:0]    out_data_q, out_data_d;
  logic [ROB_ID_W-1:0] out_id_q,   out_id_d;
  logic                crdt_err_q, crdt_err_d;

  logic acc;
  logic drain;

  // The register can take a new request when it is empty or emptying this
  // cycle. The credit term uses registered state only, so a credit returned
  // this cycle is not usable until the next one.
  assign u_req_ready = (crdt_cnt_q != '0) && (!out_vld_q || d_req_ready);
  assign acc         = u_req_valid && u_req_ready;
  assign drain       = out_vld_q && d_req_ready;

  // NOTE: every signal assigned in an always_comb gets a default first. If a
  // branch leaves a signal unassigned, synthesis infers a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;

    if (acc) begin
      // Accepting while draining reloads the register in the same cycle, so
      // back-to-back requests go through without a bubble.
      out_vld_d  = 1'b1;
      out_data_d = u_req_data;
      out_id_d   = wr_ptr_q;
      // Power-of-two depth: the pointer wraps on its own width.
      wr_ptr_d   = wr_ptr_q + PTR_ONE;
    end else if (drain) begin
      out_vld_d  = 1'b0;
    end
  end

  always_comb begin
    crdt_cnt_d = crdt_cnt_q;
    crdt_err_d = crdt_err_q;

    unique case ({acc, u_crdt_rtn})
      2'b10: crdt_cnt_d = crdt_cnt_q - CRDT_ONE;
      2'b01: begin
        // A return while already full is dropped and flagged. No credit is
        // created out of nothing.
        if (crdt_cnt_q == CRDT_FULL) crdt_err_d = 1'b1;
        else                         crdt_cnt_d = crdt_cnt_q + CRDT_ONE;
      end
      default: ;  // neither, or both cancelling out
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      crdt_cnt_q <= CRDT_FULL;
      wr_ptr_q   <= '0;
      out_vld_q  <= 1'b0;
      // NOTE: the payload register is reset as well, because d_req_data must
      // read zero after reset. Plain data storage normally stays unreset.
      out_data_q <= '0;
      out_id_q   <= '0;
      crdt_err_q <= 1'b0;
    end else begin
      crdt_cnt_q <= crdt_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      crdt_err_q <= crdt_err_d;
    end
  end

  assign d_req_valid  = out_vld_q;
  assign d_req_data   = out_data_q;
  assign d_req_rob_id = out_id_q;
  assign crdt_cnt     = crdt_cnt_q;
  assign crdt_err     = crdt_err_q;

endmodule

// File: tb/tb_rob_isu_alloc.sv
// -----------------------------------------------------------------------------
// tb_rob_isu_alloc
//
// Directed bench for rob_isu_alloc with ROB_SIZE=8. Inputs are driven 1 ns
// after each rising edge. Outputs are sampled at that same point, so
// registered outputs show the state after the edge and combinational outputs
// reflect the freshly driven inputs.
// -----------------------------------------------------------------------------
module tb_rob_isu_alloc;

  localparam int ROB_SIZE = 8;
  localparam int ROB_ID_W = 3;
  localparam int REQ_W    = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic                u_req_valid;
  logic                u_req_ready;
  logic [REQ_W-1:0]    u_req_data;
  logic                d_req_valid;
  logic                d_req_ready;
  logic [REQ_W-1:0]    d_req_data;
  logic [ROB_ID_W-1:0] d_req_rob_id;
  logic                u_crdt_rtn;
  logic [ROB_ID_W:0]   crdt_cnt;
  logic                crdt_err;

  int checks   = 0;
  int failures = 0;

  rob_isu_alloc #(
    .ROB_SIZE (ROB_SIZE),
    .ROB_ID_W (ROB_ID_W),
    .REQ_W    (REQ_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .u_req_valid  (u_req_valid),
    .u_req_ready  (u_req_ready),
    .u_req_data   (u_req_data),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_data   (d_req_data),
    .d_req_rob_id (d_req_rob_id),
    .u_crdt_rtn   (u_crdt_rtn),
    .crdt_cnt     (crdt_cnt),
    .crdt_err     (crdt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    u_req_valid = 1'b0;
    u_req_data  = '0;
    d_req_ready = 1'b1;
    u_crdt_rtn  = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_d_valid", 64'(d_req_valid),  64'd0);
    check("rst_d_data",  d_req_data,        64'd0);
    check("rst_rob_id",  64'(d_req_rob_id), 64'd0);
    check("rst_crdt",    64'(crdt_cnt),     64'd8);
    check("rst_err",     64'(crdt_err),     64'd0);
    check("rst_ready",   64'(u_req_ready),  64'd1);

    // Back-to-back: 8 accepts, ids 0..7, each visible one cycle later
    for (int i = 0; i < 8; i++) begin
      u_req_valid = 1'b1;
      u_req_data  = 64'hA000 + 64'(i);
      #1;
      check($sformatf("b2b_ready_%0d", i), 64'(u_req_ready), 64'd1);
      step();
      check($sformatf("b2b_valid_%0d", i), 64'(d_req_valid),  64'd1);
      check($sformatf("b2b_id_%0d", i),    64'(d_req_rob_id), 64'(i));
      check($sformatf("b2b_data_%0d", i),  d_req_data,        64'hA000 + 64'(i));
      check($sformatf("b2b_crdt_%0d", i),  64'(crdt_cnt),     64'(7 - i));
    end
    // 9th request is blocked by credits
    u_req_data = 64'hA008;
    #1;
    check("ninth_ready", 64'(u_req_ready), 64'd0);
    check("ninth_crdt",  64'(crdt_cnt),    64'd0);
    step();
    check("ninth_drained", 64'(d_req_valid), 64'd0);
    check("ninth_crdt2",   64'(crdt_cnt),    64'd0);

    // Credit recovery: no same-cycle bypass, usable next cycle, id wraps to 0
    u_req_valid = 1'b0;
    u_crdt_rtn  = 1'b1;
    #1;
    check("rtn_no_bypass", 64'(u_req_ready), 64'd0);
    step();
    u_crdt_rtn = 1'b0;
    #1;
    check("rtn_crdt",  64'(crdt_cnt),    64'd1);
    check("rtn_ready", 64'(u_req_ready), 64'd1);
    u_req_valid = 1'b1;
    u_req_data  = 64'hB000;
    step();
    u_req_valid = 1'b0;
    check("wrap_id",    64'(d_req_rob_id), 64'd0);
    check("wrap_data",  d_req_data,        64'hB000);
    check("wrap_crdt",  64'(crdt_cnt),     64'd0);
    check("wrap_ready", 64'(u_req_ready),  64'd0);

    // Backpressure: refill 4 credits while held, then hold 5 cycles
    d_req_ready = 1'b0;
    u_crdt_rtn  = 1'b1;
    repeat (4) step();
    u_crdt_rtn = 1'b0;
    check("bp_crdt", 64'(crdt_cnt), 64'd4);
    u_req_valid = 1'b1;
    u_req_data  = 64'hC000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_valid_%0d", i), 64'(d_req_valid),  64'd1);
      check($sformatf("bp_data_%0d", i),  d_req_data,        64'hB000);
      check($sformatf("bp_id_%0d", i),    64'(d_req_rob_id), 64'd0);
      check($sformatf("bp_ready_%0d", i), 64'(u_req_ready),  64'd0);
      step();
    end
    // Release: drain + accept in the same cycle, no bubble
    d_req_ready = 1'b1;
    #1;
    check("rel_ready", 64'(u_req_ready), 64'd1);
    step();
    check("rel_valid", 64'(d_req_valid),  64'd1);
    check("rel_id",    64'(d_req_rob_id), 64'd1);
    check("rel_data",  d_req_data,        64'hC000);
    check("rel_crdt",  64'(crdt_cnt),     64'd3);

    // Accept and return together at crdt_cnt=3
    u_req_data = 64'hD000;
    u_crdt_rtn = 1'b1;
    step();
    u_crdt_rtn = 1'b0;
    check("both_crdt", 64'(crdt_cnt),     64'd3);
    check("both_id",   64'(d_req_rob_id), 64'd2);
    u_req_data = 64'hD001;
    step();
    check("after_both_id",   64'(d_req_rob_id), 64'd3);
    check("after_both_crdt", 64'(crdt_cnt),     64'd2);
    u_req_valid = 1'b0;

    // Refill to full (6 outstanding), then one extra return overflows
    u_crdt_rtn = 1'b1;
    repeat (6) step();
    check("full_crdt", 64'(crdt_cnt), 64'd8);
    check("full_err",  64'(crdt_err), 64'd0);
    step();
    u_crdt_rtn = 1'b0;
    check("ovf_crdt", 64'(crdt_cnt), 64'd8);
    check("ovf_err",  64'(crdt_err), 64'd1);

    // Sticky through traffic; ids continue from 4
    u_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u_req_data = 64'hE000 + 64'(i);
      step();
      check($sformatf("sticky_err_%0d", i), 64'(crdt_err),     64'd1);
      check($sformatf("sticky_id_%0d", i),  64'(d_req_rob_id), 64'(4 + i));
    end
    u_req_valid = 1'b0;
    d_req_ready = 1'b0;
    step();
    check("pre_rst_valid", 64'(d_req_valid), 64'd1);

    // Mid-transfer reset discards the held request and clears everything
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_valid", 64'(d_req_valid),  64'd0);
    check("mrst_err",   64'(crdt_err),     64'd0);
    check("mrst_crdt",  64'(crdt_cnt),     64'd8);
    check("mrst_id",    64'(d_req_rob_id), 64'd0);
    check("mrst_data",  d_req_data,        64'd0);
    d_req_ready = 1'b1;
    u_req_valid = 1'b1;
    u_req_data  = 64'hF000;
    step();
    u_req_valid = 1'b0;
    check("post_rst_id",   64'(d_req_rob_id), 64'd0);
    check("post_rst_data", d_req_data,        64'hF000);
    check("post_rst_crdt", 64'(crdt_cnt),     64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
